csi2tx_dphy_clk_lane_ctrl: RTL and testbench

- Sequences the D-PHY clock lane of the CSI-2 transmitter through the LP-to-HS and HS-to-LP transitions.
- Drives the LP line levels and the HS driver enable.
- Drives the enable that lets the HS DDR clock, and the byte clock derived from it, reach the clock lane serializer.
- Runs on the escape clock. Timing values are programmed as counts of escape clock cycles.

---
 rtl/csi2tx_dphy_clk_lane_ctrl.sv | 162 ++++++++++++++++
 tb/tb_csi2tx_dphy_clk_lane_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2tx_dphy_clk_lane_ctrl.sv
// rtl/csi2tx_dphy_clk_lane_ctrl.sv - D-PHY clock lane LP<->HS transition sequencer on the escape clock
module csi2tx_dphy_clk_lane_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             txclkesc,
  input  logic             rst,
  input  logic             txrequesths,
  input  logic [CNT_W-1:0] cfg_t_lpx,
  input  logic [CNT_W-1:0] cfg_t_clk_prepare,
  input  logic [CNT_W-1:0] cfg_t_clk_zero,
  input  logic [CNT_W-1:0] cfg_t_clk_post,
  input  logic [CNT_W-1:0] cfg_t_clk_trail,
  input  logic [CNT_W-1:0] cfg_t_hs_exit,
  output logic             lp_dp,
  output logic             lp_dn,
  output logic             hs_en,
  output logic             ddrclk_en,
  output logic             stopstate,
  output logic             clk_active
);

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_HS_RQST  = 3'd1,
    ST_BRIDGE   = 3'd2,
    ST_HS_ZERO  = 3'd3,
    ST_HS_CLK   = 3'd4,
    ST_HS_POST  = 3'd5,
    ST_HS_TRAIL = 3'd6,
    ST_HS_EXIT  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A programmed value of 0 is treated as 1 cycle.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] cfg);
    return (cfg == '0) ? '0 : cfg - CNT_W'(1);
  endfunction

  always_ff @(posedge txclkesc or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (txrequesths) begin
          state_d = ST_HS_RQST;
          cnt_d   = load_val(cfg_t_lpx);
        end
      end
      ST_HS_RQST: begin
        if (cnt_q == '0) begin
          state_d = ST_BRIDGE;
          cnt_d   = load_val(cfg_t_clk_prepare);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BRIDGE: begin
        if (cnt_q == '0) begin
          state_d = ST_HS_ZERO;
          cnt_d   = load_val(cfg_t_clk_zero);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HS_ZERO: begin
        if (cnt_q == '0) begin
          state_d = ST_HS_CLK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HS_CLK: begin
        cnt_d = '0;
        if (!txrequesths) begin
          state_d = ST_HS_POST;
          cnt_d   = load_val(cfg_t_clk_post);
        end
      end
      ST_HS_POST: begin
        if (cnt_q == '0) begin
          state_d = ST_HS_TRAIL;
          cnt_d   = load_val(cfg_t_clk_trail);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HS_TRAIL: begin
        if (cnt_q == '0) begin
          state_d = ST_HS_EXIT;
          cnt_d   = load_val(cfg_t_hs_exit);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HS_EXIT: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are a pure decode of the state flop, so reset reaches them without a clock edge.
  always_comb begin
    lp_dp      = 1'b1;
    lp_dn      = 1'b1;
    hs_en      = 1'b0;
    ddrclk_en  = 1'b0;
    stopstate  = 1'b0;
    clk_active = 1'b0;
    case (state_q)
      ST_STOP: stopstate = 1'b1;
      ST_HS_RQST: lp_dp = 1'b0;
      ST_BRIDGE: begin
        lp_dp = 1'b0;
        lp_dn = 1'b0;
      end
      ST_HS_ZERO, ST_HS_TRAIL: begin
        lp_dp = 1'b0;
        lp_dn = 1'b0;
        hs_en = 1'b1;
      end
      ST_HS_CLK: begin
        lp_dp      = 1'b0;
        lp_dn      = 1'b0;
        hs_en      = 1'b1;
        ddrclk_en  = 1'b1;
        clk_active = 1'b1;
      end
      ST_HS_POST: begin
        lp_dp     = 1'b0;
        lp_dn     = 1'b0;
        hs_en     = 1'b1;
        ddrclk_en = 1'b1;
      end
      ST_HS_EXIT: ;
      default: stopstate = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_csi2tx_dphy_clk_lane_ctrl.sv
// tb/tb_csi2tx_dphy_clk_lane_ctrl.sv - bench for the D-PHY clock lane sequencer
module tb_csi2tx_dphy_clk_lane_ctrl;

  localparam int CNT_W = 8;

  // Output tuples {lp_dp, lp_dn, hs_en, ddrclk_en, stopstate, clk_active}
  localparam logic [5:0] O_STOP   = 6'b110010;
  localparam logic [5:0] O_RQST   = 6'b010000;
  localparam logic [5:0] O_BRIDGE = 6'b000000;
  localparam logic [5:0] O_ZERO   = 6'b001000;
  localparam logic [5:0] O_CLK    = 6'b001101;
  localparam logic [5:0] O_POST   = 6'b001100;
  localparam logic [5:0] O_TRAIL  = 6'b001000;
  localparam logic [5:0] O_EXIT   = 6'b110000;

  logic             txclkesc = 1'b0;
  logic             rst = 1'b1;
  logic             txrequesths = 1'b0;
  logic [CNT_W-1:0] cfg_t_lpx = '0;
  logic [CNT_W-1:0] cfg_t_clk_prepare = '0;
  logic [CNT_W-1:0] cfg_t_clk_zero = '0;
  logic [CNT_W-1:0] cfg_t_clk_post = '0;
  logic [CNT_W-1:0] cfg_t_clk_trail = '0;
  logic [CNT_W-1:0] cfg_t_hs_exit = '0;
  logic             lp_dp, lp_dn, hs_en, ddrclk_en, stopstate, clk_active;
  logic [5:0]       dut_out;

  int checks = 0;
  int errors = 0;

  assign dut_out = {lp_dp, lp_dn, hs_en, ddrclk_en, stopstate, clk_active};

  always #5 txclkesc = ~txclkesc;

  csi2tx_dphy_clk_lane_ctrl #(.CNT_W(CNT_W)) dut (
    .txclkesc          (txclkesc),
    .rst               (rst),
    .txrequesths       (txrequesths),
    .cfg_t_lpx         (cfg_t_lpx),
    .cfg_t_clk_prepare (cfg_t_clk_prepare),
    .cfg_t_clk_zero    (cfg_t_clk_zero),
    .cfg_t_clk_post    (cfg_t_clk_post),
    .cfg_t_clk_trail   (cfg_t_clk_trail),
    .cfg_t_hs_exit     (cfg_t_hs_exit),
    .lp_dp             (lp_dp),
    .lp_dn             (lp_dn),
    .hs_en             (hs_en),
    .ddrclk_en         (ddrclk_en),
    .stopstate         (stopstate),
    .clk_active        (clk_active)
  );

  // Model: each accepted request or drop schedules a whole run of expected output tuples.
  logic [5:0] exp_q[$];
  logic [5:0] exp_out = O_STOP;
  bit         in_clk = 1'b0;

  function automatic int mx1(input logic [CNT_W-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  task automatic push_n(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  initial forever begin
    @(posedge txclkesc or posedge rst);
    if (rst) begin
      exp_q.delete();
      in_clk  = 1'b0;
      exp_out = O_STOP;
    end else if (exp_q.size() > 0) begin
      exp_out = exp_q.pop_front();
    end else if (!in_clk) begin
      if (txrequesths) begin
        push_n(O_RQST, mx1(cfg_t_lpx));
        push_n(O_BRIDGE, mx1(cfg_t_clk_prepare));
        push_n(O_ZERO, mx1(cfg_t_clk_zero));
        push_n(O_CLK, 1);
        in_clk  = 1'b1;
        exp_out = exp_q.pop_front();
      end else begin
        exp_out = O_STOP;
      end
    end else begin
      if (!txrequesths) begin
        push_n(O_POST, mx1(cfg_t_clk_post));
        push_n(O_TRAIL, mx1(cfg_t_clk_trail));
        push_n(O_EXIT, mx1(cfg_t_hs_exit));
        push_n(O_STOP, 1);
        in_clk  = 1'b0;
        exp_out = exp_q.pop_front();
      end else begin
        exp_out = O_CLK;
      end
    end
  end

  logic prev_ddr = 1'b0;
  logic prev_hs = 1'b0;

  initial forever begin
    @(negedge txclkesc);
    checks++;
    if (dut_out !== exp_out) begin
      errors++;
      $display("FAIL model_cycle t=%0t got %b want %b", $time, dut_out, exp_out);
    end
    if (!rst && ddrclk_en !== prev_ddr) begin
      checks++;
      if (!(hs_en && prev_hs)) begin
        errors++;
        $display("FAIL ddr_gate t=%0t hs_en %b->%b want 1->1", $time, prev_hs, hs_en);
      end
    end
    prev_ddr = ddrclk_en;
    prev_hs  = hs_en;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge txclkesc);
    #1;
  endtask

  // sel 0: stop at clk_active, sel 1: stop at stopstate; n=-1 on timeout
  task automatic count_until(input int sel, output int n, output int ddr_n,
                             output int hs_n, output int z_n, output int ca_n);
    n = 0; ddr_n = 0; hs_n = 0; z_n = 0; ca_n = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      n++;
      if (ddrclk_en) ddr_n++;
      if (hs_en) hs_n++;
      if (hs_en && !ddrclk_en) z_n++;
      if (clk_active) ca_n++;
      if ((sel == 0) ? clk_active : stopstate) return;
    end
    n = -1;
  endtask

  task automatic set_cfg(input int lpx, input int prep, input int zero,
                         input int post, input int trail, input int hexit);
    cfg_t_lpx         = CNT_W'(lpx);
    cfg_t_clk_prepare = CNT_W'(prep);
    cfg_t_clk_zero    = CNT_W'(zero);
    cfg_t_clk_post    = CNT_W'(post);
    cfg_t_clk_trail   = CNT_W'(trail);
    cfg_t_hs_exit     = CNT_W'(hexit);
  endtask

  int n, ddr_n, hs_n, z_n, ca_n;

  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk("reset_state", int'(dut_out), int'(O_STOP));
    rst = 1'b0;
    repeat (2) step();
    chk("idle_stop", int'(dut_out), int'(O_STOP));

    set_cfg(3, 2, 5, 4, 3, 6);
    txrequesths = 1'b1;
    count_until(0, n, ddr_n, hs_n, z_n, ca_n);
    chk("entry_latency", n, 11);
    chk("entry_zero_len", z_n, 5);
    repeat (3) step();
    txrequesths = 1'b0;
    count_until(1, n, ddr_n, hs_n, z_n, ca_n);
    chk("exit_latency", n, 14);
    chk("exit_ddr_len", ddr_n, 4);
    chk("exit_hs_len", hs_n, 7);
    step();

    set_cfg(0, 0, 0, 0, 0, 0);
    txrequesths = 1'b1;
    count_until(0, n, ddr_n, hs_n, z_n, ca_n);
    chk("zero_cfg_entry", n, 4);
    txrequesths = 1'b0;
    count_until(1, n, ddr_n, hs_n, z_n, ca_n);
    chk("zero_cfg_exit", n, 4);
    step();

    set_cfg(1, 1, 1, 2, 2, 2);
    txrequesths = 1'b1;
    step();
    txrequesths = 1'b0;
    count_until(1, n, ddr_n, hs_n, z_n, ca_n);
    chk("pulse_clk_len", ca_n, 1);
    chk("pulse_total", n, 10);
    step();

    txrequesths = 1'b1;
    count_until(0, n, ddr_n, hs_n, z_n, ca_n);
    chk("rereq_entry", n, 4);
    txrequesths = 1'b0;
    repeat (3) step();
    chk("in_trail", int'(dut_out), int'(O_TRAIL));
    txrequesths = 1'b1;
    count_until(1, n, ddr_n, hs_n, z_n, ca_n);
    chk("rereq_to_stop", n, 4);
    step();
    chk("rereq_rqst", int'(dut_out), int'(O_RQST));
    txrequesths = 1'b0;
    count_until(1, n, ddr_n, hs_n, z_n, ca_n);
    chk("rereq_cycle", n, 10);
    step();

    set_cfg(1, 1, 5, 2, 2, 2);
    txrequesths = 1'b1;
    repeat (3) step();
    chk("zero_first", int'(dut_out), int'(O_ZERO));
    step();
    cfg_t_clk_zero = CNT_W'(1);
    count_until(0, n, ddr_n, hs_n, z_n, ca_n);
    chk("cfg_change_zero_len", z_n + 2, 5);

    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", int'(dut_out), int'(O_STOP));
    txrequesths = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    chk("post_reset_stop", int'(dut_out), int'(O_STOP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
